// File: rtl/timer_sel_countdown_if.sv
// Control and status bundle for the selectable countdown timer.
// The master drives the controls and the slave reports selection and countdown.
interface timer_sel_countdown_if #(
  parameter int NUM_TIMES = 3,
  parameter int SEL_W     = 2,
  parameter int CNT_W     = 8
);
  logic                 i_enable;
  logic                 i_btn;
  logic                 i_tick;
  logic [SEL_W-1:0]     o_sel;
  logic [NUM_TIMES-1:0] o_time_led;
  logic [CNT_W-1:0]     o_remaining;
  logic                 o_time_active;
  logic                 o_expire;

  modport master (
    output i_enable, i_btn, i_tick,
    input  o_sel, o_time_led, o_remaining,
    input  o_time_active, o_expire
  );

  modport slave (
    input  i_enable, i_btn, i_tick,
    output o_sel, o_time_led, o_remaining,
    output o_time_active, o_expire
  );
endinterface

// File: rtl/timer_sel_countdown.sv
// Button-cycled timer presets (k*UNIT_TICKS) counted down by a tick strobe.
// Expiry returns the selection to OFF with a one-cycle pulse.
module timer_sel_countdown #(
  parameter int NUM_TIMES  = 3,
  parameter int SEL_W      = 2,
  parameter int UNIT_TICKS = 10,
  parameter int CNT_W      = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  timer_sel_countdown_if.slave bus
);

  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_TIMES);
  localparam logic [CNT_W-1:0] UNIT    = CNT_W'(UNIT_TICKS);

  logic [SEL_W-1:0] sel_q;
  logic [CNT_W-1:0] rem_q;
  logic             exp_q;
  logic [SEL_W-1:0] next_sel;
  logic [CNT_W-1:0] preset;

  assign next_sel = (sel_q == SEL_MAX) ? '0 : sel_q + SEL_W'(1);
  // Widen before multiplying so the preset never truncates.
  assign preset   = CNT_W'(next_sel) * UNIT;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sel_q <= '0;
      rem_q <= '0;
      exp_q <= 1'b0;
    end else begin
      exp_q <= 1'b0;
      if (!bus.i_enable) begin
        sel_q <= '0;
        rem_q <= '0;
      end else if (bus.i_btn) begin
        sel_q <= next_sel;
        rem_q <= preset;
      end else if (bus.i_tick && sel_q != '0 && rem_q != '0) begin
        rem_q <= rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          sel_q <= '0;
          exp_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.o_time_led = '0;
    for (int k = 0; k < NUM_TIMES; k++) begin
      bus.o_time_led[k] = (sel_q == SEL_W'(k + 1));
    end
  end

  assign bus.o_sel         = sel_q;
  assign bus.o_remaining   = rem_q;
  assign bus.o_expire      = exp_q;
  assign bus.o_time_active = (sel_q != '0);

endmodule
